// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package tour_pkg;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;
    localparam logic [7:0] HEAD_W = 8'h3F;

    localparam logic [7:0] MV0 = 8'b0000_0001;
    localparam logic [7:0] MV1 = 8'b0000_0010;
    localparam logic [7:0] MV2 = 8'b0000_0100;
    localparam logic [7:0] MV3 = 8'b0000_1000;
    localparam logic [7:0] MV4 = 8'b0001_0000;
    localparam logic [7:0] MV5 = 8'b0010_0000;
    localparam logic [7:0] MV6 = 8'b0100_0000;
    localparam logic [7:0] MV7 = 8'b1000_0000;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_POS = 8'h5A;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

endpackage

// File: rtl/tour_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
module tour_move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output logic [7:0] vhead,
    output logic [3:0] vsq,
    output logic [7:0] hhead,
    output logic [3:0] hsq
);

    // Heading/length per leg; anything not one-hot becomes a zero-length north move.
    always_comb begin
        vhead = HEAD_N;
        vsq   = 4'd0;
        hhead = HEAD_N;
        hsq   = 4'd0;
        case (move)
            MV0: begin vhead = HEAD_N; vsq = 4'd2; hhead = HEAD_E; hsq = 4'd1; end
            MV1: begin vhead = HEAD_N; vsq = 4'd2; hhead = HEAD_W; hsq = 4'd1; end
            MV2: begin vhead = HEAD_N; vsq = 4'd1; hhead = HEAD_W; hsq = 4'd2; end
            MV3: begin vhead = HEAD_S; vsq = 4'd1; hhead = HEAD_W; hsq = 4'd2; end
            MV4: begin vhead = HEAD_S; vsq = 4'd2; hhead = HEAD_W; hsq = 4'd1; end
            MV5: begin vhead = HEAD_S; vsq = 4'd2; hhead = HEAD_E; hsq = 4'd1; end
            MV6: begin vhead = HEAD_S; vsq = 4'd1; hhead = HEAD_E; hsq = 4'd2; end
            MV7: begin vhead = HEAD_N; vsq = 4'd1; hhead = HEAD_E; hsq = 4'd2; end
            default: begin
                vhead = HEAD_N;
                vsq   = 4'd0;
                hhead = HEAD_N;
                hsq   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Command-path sequencer: UART passthrough when idle, solver tour playback otherwise.
module tour_cmd
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_active
);

    state_t           state_r;
    logic [IDX_W-1:0] mv_indx_r;
    logic [7:0]       resp_r;
    logic [7:0]       vhead_s;
    logic [3:0]       vsq_s;
    logic [7:0]       hhead_s;
    logic [3:0]       hsq_s;

    tour_move_decode u_decode (
        .move  (move),
        .vhead (vhead_s),
        .vsq   (vsq_s),
        .hhead (hhead_s),
        .hsq   (hsq_s)
    );

    // Tour FSM with move index and response byte; send_resp only counts in the wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mv_indx_r <= 5'd0;
            resp_r    <= RESP_ACK;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx_r <= 5'd0;
                        state_r   <= VERT;
                    end
                end
                VERT: begin
                    if (clr_cmd_rdy) state_r <= WAIT_V;
                end
                WAIT_V: begin
                    if (send_resp) begin
                        state_r <= HORZ;
                        resp_r  <= RESP_POS;
                    end
                end
                HORZ: begin
                    if (clr_cmd_rdy) state_r <= WAIT_H;
                end
                WAIT_H: begin
                    if (send_resp) begin
                        if (mv_indx_r == LAST_IDX) begin
                            state_r <= IDLE;
                            resp_r  <= RESP_ACK;
                        end else begin
                            mv_indx_r <= mv_indx_r + 5'd1;
                            state_r   <= VERT;
                            resp_r    <= RESP_POS;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mv_indx_r <= 5'd0;
                    resp_r    <= RESP_ACK;
                end
            endcase
        end
    end

    // Command path mux; the UART side is combinational so its handshake stays same-cycle.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        case (state_r)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
            VERT, WAIT_V: begin
                cmd              = {OP_MOVE, vhead_s, vsq_s};
                cmd_rdy          = (state_r == VERT);
                clr_cmd_rdy_UART = 1'b0;
            end
            HORZ, WAIT_H: begin
                cmd              = {OP_FANFARE, hhead_s, hsq_s};
                cmd_rdy          = (state_r == HORZ);
                clr_cmd_rdy_UART = 1'b0;
            end
            default: begin
                cmd              = 16'h0000;
                cmd_rdy          = 1'b0;
                clr_cmd_rdy_UART = 1'b0;
            end
        endcase
    end

    assign mv_indx     = mv_indx_r;
    assign resp        = resp_r;
    assign tour_active = (state_r != IDLE);

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: leg-level reference model plus directed literal checks.
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        tour_active;

    logic [7:0]  mv_mem [0:23];
    int          total = 0;
    int          bad = 0;

    // Reference model: a tour is 48 legs; each leg is either offered or awaiting its response.
    bit          m_active = 1'b0;
    int          m_leg = 0;
    bit          m_wait = 1'b0;
    logic [7:0]  m_resp = 8'hA5;

    int          dut_cmds = 0;
    bit          cnt_clr = 1'b0;

    int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    logic [15:0] vexp [8] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                              16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
    logic [15:0] hexp [8] = '{16'h3BF1, 16'h33F1, 16'h33F2, 16'h33F2,
                              16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

    always #5 clk = ~clk;

    assign move = (mv_indx < 5'd24) ? mv_mem[mv_indx] : 8'h00;

    tour_cmd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .tour_active      (tour_active)
    );

    function automatic logic [15:0] leg_cmd(logic [7:0] mv, bit horiz);
        int n = 0;
        int k = 0;
        int d;
        logic [7:0] head;
        for (int i = 0; i < 8; i++) begin
            if (mv[i]) begin
                n++;
                k = i;
            end
        end
        if (n != 1) return horiz ? 16'h3000 : 16'h2000;
        if (horiz) begin
            d = dx_t[k];
            head = (d > 0) ? 8'hBF : 8'h3F;
            return {4'h3, head, 4'(d < 0 ? -d : d)};
        end
        d = dy_t[k];
        head = (d > 0) ? 8'h00 : 8'h7F;
        return {4'h2, head, 4'(d < 0 ? -d : d)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model update from the inputs seen at each active edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_leg    <= 0;
            m_wait   <= 1'b0;
            m_resp   <= 8'hA5;
        end else if (!m_active) begin
            if (start_tour) begin
                m_active <= 1'b1;
                m_leg    <= 0;
                m_wait   <= 1'b0;
            end
        end else if (!m_wait) begin
            if (clr_cmd_rdy) m_wait <= 1'b1;
        end else if (send_resp) begin
            if (m_leg == 47) begin
                m_active <= 1'b0;
                m_resp   <= 8'hA5;
            end else begin
                m_leg  <= m_leg + 1;
                m_wait <= 1'b0;
                m_resp <= 8'h5A;
            end
        end
    end

    // Counts tour commands actually consumed from the DUT.
    always @(posedge clk) begin
        if (cnt_clr) dut_cmds <= 0;
        else if (tour_active && cmd_rdy && clr_cmd_rdy) dut_cmds <= dut_cmds + 1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("tour_active", 32'(tour_active), 32'(m_active));
        chk("mv_indx", 32'(mv_indx), 32'(m_leg / 2));
        chk("resp", 32'(resp), 32'(m_resp));
        if (!m_active) begin
            chk("pt_cmd", 32'(cmd), 32'(cmd_UART));
            chk("pt_cmd_rdy", 32'(cmd_rdy), 32'(cmd_rdy_UART));
            chk("pt_clr", 32'(clr_cmd_rdy_UART), 32'(clr_cmd_rdy));
        end else begin
            chk("tour_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
            chk("tour_cmd_rdy", 32'(cmd_rdy), 32'(!m_wait));
            if (!m_wait)
                chk("tour_cmd", 32'(cmd), 32'(leg_cmd(mv_mem[m_leg / 2], (m_leg % 2) == 1)));
        end
    end

    task automatic run_tour(int maxd);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) mv_mem[i] = 8'($urandom);
            else mv_mem[i] = 8'h01 << $urandom_range(0, 7);
        end
        cnt_clr = 1'b1;
        start_tour = 1'b1;
        tick();
        cnt_clr = 1'b0;
        start_tour = 1'b0;
        for (int leg = 0; leg < 48; leg++) begin
            repeat ($urandom_range(0, maxd)) begin
                send_resp    = ($urandom_range(0, 3) == 0);
                start_tour   = 1'($urandom);
                cmd_rdy_UART = 1'($urandom);
                cmd_UART     = 16'($urandom);
                tick();
            end
            send_resp   = ($urandom_range(0, 3) == 0);
            start_tour  = 1'b0;
            clr_cmd_rdy = 1'b1;
            tick();
            clr_cmd_rdy = 1'b0;
            send_resp   = 1'b0;
            repeat ($urandom_range(0, maxd)) begin
                start_tour = 1'($urandom);
                tick();
            end
            start_tour = 1'b0;
            if (leg == 47) begin
                @(negedge clk);
                chk("active_before_last", 32'(tour_active), 32'd1);
                @(posedge clk);
                #1;
            end
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
        end
        @(negedge clk);
        chk("tour_done_active", 32'(tour_active), 32'd0);
        chk("tour_done_resp", 32'(resp), 32'hA5);
        chk("tour_done_indx", 32'(mv_indx), 32'd23);
        chk("tour_cmd_count", 32'(dut_cmds), 32'd48);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 24; i++) mv_mem[i] = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // UART passthrough
        cmd_UART = 16'h2003;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        chk("pass_cmd", 32'(cmd), 32'h2003);
        chk("pass_rdy", 32'(cmd_rdy), 32'd1);
        chk("pass_clr", 32'(clr_cmd_rdy_UART), 32'd1);
        chk("pass_resp", 32'(resp), 32'hA5);
        tick();
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;

        // Each move bit in turn, with stale/overlap and reset cases
        for (int i = 0; i < 8; i++) mv_mem[i] = 8'h01 << i;
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("dir_vcmd", 32'(cmd), 32'(vexp[i]));
            chk("dir_vrdy", 32'(cmd_rdy), 32'd1);
            chk("dir_indx", 32'(mv_indx), 32'(i));
            if (i == 0) chk("first_resp", 32'(resp), 32'hA5);
            @(posedge clk);
            #1;
            if (i == 1) begin
                send_resp = 1'b1;
                tick();
                send_resp = 1'b0;
                @(negedge clk);
                chk("stale_rdy", 32'(cmd_rdy), 32'd1);
                chk("stale_cmd", 32'(cmd), 32'(vexp[i]));
                @(posedge clk);
                #1;
                clr_cmd_rdy = 1'b1;
                send_resp = 1'b1;
                tick();
                clr_cmd_rdy = 1'b0;
                send_resp = 1'b0;
                tick();
                @(negedge clk);
                chk("overlap_wait", 32'(cmd_rdy), 32'd0);
                chk("overlap_resp", 32'(resp), 32'h5A);
                @(posedge clk);
                #1;
            end else begin
                clr_cmd_rdy = 1'b1;
                tick();
                clr_cmd_rdy = 1'b0;
            end
            start_tour = 1'b1;
            cmd_rdy_UART = 1'b1;
            clr_cmd_rdy = 1'b1;
            @(negedge clk);
            chk("ign_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
            chk("ign_rdy", 32'(cmd_rdy), 32'd0);
            tick();
            start_tour = 1'b0;
            cmd_rdy_UART = 1'b0;
            clr_cmd_rdy = 1'b0;
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            @(negedge clk);
            chk("dir_hcmd", 32'(cmd), 32'(hexp[i]));
            chk("dir_hresp", 32'(resp), 32'h5A);
            @(posedge clk);
            #1;
            if (i == 7) begin
                rst_n = 1'b0;
                cmd_rdy_UART = 1'b1;
                @(negedge clk);
                chk("rst_active", 32'(tour_active), 32'd0);
                chk("rst_indx", 32'(mv_indx), 32'd0);
                chk("rst_rdy", 32'(cmd_rdy), 32'd1);
                tick();
                rst_n = 1'b1;
                cmd_rdy_UART = 1'b0;
                tick();
            end else begin
                clr_cmd_rdy = 1'b1;
                tick();
                clr_cmd_rdy = 1'b0;
                send_resp = 1'b1;
                tick();
                send_resp = 1'b0;
            end
        end

        run_tour(0);
        run_tour(3);
        run_tour(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
Sequencer between the knight's-tour solver and the command processor. While the solver is idle, UART commands pass straight through to the command processor. On start_tour the block takes over the command path. It reads the 24 solved moves out of the solver by index and splits each L-shaped move into two commands: a vertical leg, then a horizontal leg with fanfare. Each command waits for the motion system's completion response before the next is issued.

Parameters:
NUM_MOVES, 24, number of moves read from the solver (indices 0..NUM_MOVES-1)
RESP_ACK, 8'hA5, response byte for UART mode and for tour completion
RESP_POS, 8'h5A, response byte for intermediate tour legs

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  one-cycle pulse: solver done, begin issuing tour
move  in  8  one-hot move from solver, addressed by mv_indx (combinational read)
mv_indx  out  5  index of move currently being executed
cmd_UART  in  16  command from UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy_UART  out  1  consume strobe back to UART wrapper
cmd  out  16  command to command processor {opcode[15:12], heading[11:4], squares[3:0]}
cmd_rdy  out  1  cmd valid
clr_cmd_rdy  in  1  command processor has consumed cmd
send_resp  in  1  command processor finished executing current command
resp  out  8  response byte to UART transmitter
tour_active  out  1  high whenever the block is not in IDLE

Behaviour:
- Reset: asynchronous, active-low rst_n; clock clk. State IDLE, mv_indx=0, tour_active=0. Outputs are the UART passthrough values, so cmd_rdy=cmd_rdy_UART, and resp=RESP_ACK.
- Move decode (combinational from move). Bit / (dx,dy):
  - b0 (+1,+2), b1 (-1,+2), b2 (-2,+1), b3 (-2,-1)
  - b4 (-1,-2), b5 (+1,-2), b6 (+2,-1), b7 (+2,+1)
- Vertical leg: heading north 8'h00 if dy>0, south 8'h7F if dy<0; squares=|dy|.
- Horizontal leg: heading east 8'hBF if dx>0, west 8'h3F if dx<0; squares=|dx|.
- Non-one-hot move: heading 8'h00, squares 0.
- Opcodes: MOVE=4'h2 for the vertical leg, MOVE_FANFARE=4'h3 for the horizontal leg.
- IDLE (UART mode):
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=RESP_ACK.
  - start_tour: mv_indx<=0, go to VERT.
- VERT: cmd={MOVE, vhead, vsq}, cmd_rdy=1. On clr_cmd_rdy, go to WAIT_V.
- WAIT_V: cmd_rdy=0. On send_resp, go to HORZ; resp=RESP_POS.
- HORZ: cmd={MOVE_FANFARE, hhead, hsq}, cmd_rdy=1. On clr_cmd_rdy, go to WAIT_H.
- WAIT_H: cmd_rdy=0. On send_resp:
  - if mv_indx==NUM_MOVES-1: go to IDLE, resp=RESP_ACK;
  - else: mv_indx<=mv_indx+1, go to VERT, resp=RESP_POS.
- Tour mode (any state other than IDLE):
  - clr_cmd_rdy_UART=0; cmd_UART and cmd_rdy_UART are ignored.
  - start_tour is ignored.
- Latency: first command is valid the cycle after start_tour. The next leg is valid the cycle after send_resp.
- Simultaneous clr_cmd_rdy and send_resp in VERT/HORZ: clr wins and send_resp is dropped as stale. send_resp in VERT/HORZ alone is ignored.
- mv_indx is held stable for the whole of both legs; it changes only on the WAIT_H to VERT transition. mv_indx never wraps: after the final leg it holds NUM_MOVES-1 until the next start_tour resets it to 0.
- Reset mid-tour: immediate return to IDLE and UART passthrough; mv_indx=0.

Decomposition:
- Package tour_pkg holds:
  - state_t enum {IDLE, VERT, WAIT_V, HORZ, WAIT_H};
  - opcode constants;
  - heading constants N/S/E/W;
  - one-hot move constants MV0..MV7;
  - RESP constants.
- Sub-module tour_move_decode: purely combinational, maps move[7:0] to {vhead, vsq, hhead, hsq}. The top holds the FSM, the mv_indx counter and the muxes.

Test Plan:
- Passthrough: in IDLE drive cmd_UART=16'h2003, cmd_rdy_UART=1, then pulse clr_cmd_rdy -> cmd=16'h2003, cmd_rdy=1, clr_cmd_rdy_UART pulses the same cycle, resp=8'hA5.
- Single decode: start_tour with move=8'h01 -> cmd=16'h2002 (north, 2 squares). After clr_cmd_rdy and send_resp -> cmd=16'h3BF1 (east, 1 square, fanfare), resp=8'h5A.
- All eight moves in turn, b1..b7 -> vertical/horizontal pairs (16'h2002/16'h33F1), (16'h2001/16'h33F2), (16'h27F1/16'h33F2), (16'h27F2/16'h33F1), (16'h27F2/16'h3BF1), (16'h27F1/16'h3BF2), (16'h2001/16'h3BF2).
- Full tour, 24 moves with random delays on clr_cmd_rdy and send_resp:
  - exactly 48 commands issued;
  - mv_indx steps 0..23;
  - final resp=8'hA5 on return to IDLE;
  - tour_active falls the cycle after the final send_resp.
- Stale/overlap:
  - send_resp asserted in VERT, before clr_cmd_rdy -> no state change;
  - clr_cmd_rdy and send_resp in the same cycle -> WAIT_V only;
  - start_tour and cmd_rdy_UART=1 mid-tour -> ignored, clr_cmd_rdy_UART stays 0.
- Reset mid-tour: assert rst_n=0 during HORZ at mv_indx=7 -> next cycle state IDLE, mv_indx=0, tour_active=0, cmd_rdy follows cmd_rdy_UART.
